// File: rtl/stream_mux_rr.sv
`default_nettype none
// ============================================================================
// Module   : stream_mux_rr
// Purpose  : Merges NSTREAMS AXI-Stream inputs onto one AXI-Stream output.
//            A grant holds one channel for exactly BURST accepted beats.
//            Grants come from a round-robin scan of valid inputs (MODE=0)
//            or from the external channel select `sel` (MODE=1). The output
//            is a two-entry registered skid stage; every beat carries its
//            source channel on m_tid.
// Ports    : aclk, aresetn      - clock, asynchronous active-low reset
//            s_tdata/s_tvalid/s_tready - packed input streams, channel i at
//                                 s_tdata[i*WIDTH +: WIDTH]
//            sel                - channel request (MODE=1 only)
//            m_tdata/m_tvalid/m_tready/m_tid - merged output stream
// Revision : 1.0 - initial release
// ============================================================================
module stream_mux_rr #(
    parameter  int NSTREAMS = 2,
    parameter  int WIDTH    = 16,
    parameter  int BURST    = 1,
    parameter  int MODE     = 0,
    localparam int SELW     = (NSTREAMS > 1) ? $clog2(NSTREAMS) : 1
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [NSTREAMS*WIDTH-1:0] s_tdata,
    input  logic [NSTREAMS-1:0]       s_tvalid,
    output logic [NSTREAMS-1:0]       s_tready,
    input  logic [SELW-1:0]           sel,
    output logic [WIDTH-1:0]          m_tdata,
    output logic                      m_tvalid,
    input  logic                      m_tready,
    output logic [SELW-1:0]           m_tid
);

    localparam int                CNTW      = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [SELW-1:0]   LAST_CH   = SELW'(NSTREAMS - 1);
    localparam logic [CNTW-1:0]   LAST_BEAT = CNTW'(BURST - 1);
    localparam logic [SELW:0]     NSTR_EXT  = (SELW + 1)'(NSTREAMS);

    typedef enum logic [0:0] {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } state_e;

    state_e                state_q,      state_d;
    logic [SELW-1:0]       grant_q,      grant_d;
    logic [SELW-1:0]       rr_ptr_q,     rr_ptr_d;
    logic [CNTW-1:0]       beat_cnt_q,   beat_cnt_d;
    logic [NSTREAMS-1:0]   s_tready_q,   s_tready_d;
    logic                  main_valid_q, main_valid_d;
    logic [WIDTH-1:0]      main_data_q,  main_data_d;
    logic [SELW-1:0]       main_id_q,    main_id_d;
    logic                  skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0]      skid_data_q,  skid_data_d;
    logic [SELW-1:0]       skid_id_q,    skid_id_d;

    logic [WIDTH-1:0]      chan_data [NSTREAMS];
    logic                  accept;
    logic                  consume;
    logic                  rr_found;
    logic [SELW-1:0]       rr_pick;
    logic                  sel_ok;
    logic [SELW-1:0]       sel_pick;

    for (genvar gi = 0; gi < NSTREAMS; gi++) begin : g_unpack
        assign chan_data[gi] = s_tdata[gi*WIDTH +: WIDTH];
    end

    // s_tready_q is only ever set for the granted channel while locked.
    assign accept  = (state_q == ST_LOCK) && s_tvalid[grant_q] && s_tready_q[grant_q];
    assign consume = main_valid_q && m_tready;

    // Round-robin scan starting at rr_ptr; first valid channel wins.
    always_comb begin
        int idx;
        idx      = 0;
        rr_found = 1'b0;
        rr_pick  = rr_ptr_q;
        for (int k = 0; k < NSTREAMS; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NSTREAMS) begin
                idx = idx - NSTREAMS;
            end
            if (!rr_found && s_tvalid[idx]) begin
                rr_found = 1'b1;
                rr_pick  = SELW'(idx);
            end
        end
    end

    // With a single stream the select is meaningless: always grant channel 0.
    assign sel_ok   = (NSTREAMS == 1) || ({1'b0, sel} < NSTR_EXT);
    assign sel_pick = (NSTREAMS == 1) ? '0 : sel;

    // Arbitration / burst FSM next state.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            ST_ARB: begin
                if (MODE == 0) begin
                    if (rr_found) begin
                        grant_d = rr_pick;
                        state_d = ST_LOCK;
                    end
                end else begin
                    if (sel_ok) begin
                        grant_d = sel_pick;
                        state_d = ST_LOCK;
                    end
                end
            end
            ST_LOCK: begin
                if (accept) begin
                    if (beat_cnt_q == LAST_BEAT) begin
                        beat_cnt_d = '0;
                        rr_ptr_d   = (grant_q == LAST_CH) ? '0 : grant_q + 1'b1;
                        state_d    = ST_ARB;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    // Output stage: main register feeds the port, skid catches the beat
    // accepted while main is held by backpressure.
    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        main_id_d    = main_id_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_id_d    = skid_id_q;
        if (consume) begin
            main_valid_d = 1'b0;
        end
        if (skid_valid_q && !main_valid_d) begin
            main_valid_d = 1'b1;
            main_data_d  = skid_data_q;
            main_id_d    = skid_id_q;
            skid_valid_d = 1'b0;
        end
        if (accept) begin
            if (!main_valid_d) begin
                main_valid_d = 1'b1;
                main_data_d  = chan_data[grant_q];
                main_id_d    = grant_q;
            end else begin
                skid_valid_d = 1'b1;
                skid_data_d  = chan_data[grant_q];
                skid_id_d    = grant_q;
            end
        end
    end

    // Ready is registered from next-state values, so it never depends
    // combinationally on m_tready yet always equals !skid_valid while locked.
    always_comb begin
        s_tready_d = '0;
        if ((state_d == ST_LOCK) && !skid_valid_d) begin
            s_tready_d[grant_d] = 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= ST_ARB;
            grant_q      <= '0;
            rr_ptr_q     <= '0;
            beat_cnt_q   <= '0;
            s_tready_q   <= '0;
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            main_id_q    <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_id_q    <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            rr_ptr_q     <= rr_ptr_d;
            beat_cnt_q   <= beat_cnt_d;
            s_tready_q   <= s_tready_d;
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            main_id_q    <= main_id_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_id_q    <= skid_id_d;
        end
    end

    assign s_tready = s_tready_q;
    assign m_tvalid = main_valid_q;
    assign m_tdata  = main_data_q;
    assign m_tid    = main_id_q;

endmodule
`default_nettype wire

// File: tb/tb_stream_mux_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_mux_rr
// Purpose  : Directed self-checking bench for stream_mux_rr. Four instances:
//            A round-robin BURST=1, B round-robin BURST=3, C external select
//            BURST=2 with five streams, D round-robin BURST=4 under random
//            output backpressure, then reset mid-burst.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_mux_rr;

    logic aclk;
    logic aresetn;
    int   n_checks;
    int   n_errors;

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // ---------------- instance A: N=4, MODE=0, BURST=1 ----------------
    logic [63:0] a_tdata;
    logic [3:0]  a_valid, a_sready;
    logic [1:0]  a_sel, a_mtid;
    logic [15:0] a_mdata;
    logic        a_mvalid, a_mready;

    stream_mux_rr #(.NSTREAMS(4), .WIDTH(16), .BURST(1), .MODE(0)) u_a (
        .aclk(aclk), .aresetn(aresetn), .s_tdata(a_tdata), .s_tvalid(a_valid),
        .s_tready(a_sready), .sel(a_sel), .m_tdata(a_mdata), .m_tvalid(a_mvalid),
        .m_tready(a_mready), .m_tid(a_mtid));

    // ---------------- instance B: N=4, MODE=0, BURST=3 ----------------
    logic [63:0] b_tdata;
    logic [3:0]  b_valid, b_sready;
    logic [1:0]  b_sel, b_mtid;
    logic [15:0] b_mdata;
    logic        b_mvalid, b_mready;

    stream_mux_rr #(.NSTREAMS(4), .WIDTH(16), .BURST(3), .MODE(0)) u_b (
        .aclk(aclk), .aresetn(aresetn), .s_tdata(b_tdata), .s_tvalid(b_valid),
        .s_tready(b_sready), .sel(b_sel), .m_tdata(b_mdata), .m_tvalid(b_mvalid),
        .m_tready(b_mready), .m_tid(b_mtid));

    // ---------------- instance C: N=5, MODE=1, BURST=2 ----------------
    logic [79:0] c_tdata;
    logic [4:0]  c_valid, c_sready;
    logic [2:0]  c_sel, c_mtid;
    logic [15:0] c_mdata;
    logic        c_mvalid, c_mready;

    stream_mux_rr #(.NSTREAMS(5), .WIDTH(16), .BURST(2), .MODE(1)) u_c (
        .aclk(aclk), .aresetn(aresetn), .s_tdata(c_tdata), .s_tvalid(c_valid),
        .s_tready(c_sready), .sel(c_sel), .m_tdata(c_mdata), .m_tvalid(c_mvalid),
        .m_tready(c_mready), .m_tid(c_mtid));

    // ---------------- instance D: N=4, MODE=0, BURST=4 ----------------
    logic [63:0] d_tdata;
    logic [3:0]  d_valid, d_sready;
    logic [1:0]  d_sel, d_mtid;
    logic [15:0] d_mdata;
    logic        d_mvalid, d_mready;

    stream_mux_rr #(.NSTREAMS(4), .WIDTH(16), .BURST(4), .MODE(0)) u_d (
        .aclk(aclk), .aresetn(aresetn), .s_tdata(d_tdata), .s_tvalid(d_valid),
        .s_tready(d_sready), .sel(d_sel), .m_tdata(d_mdata), .m_tvalid(d_mvalid),
        .m_tready(d_mready), .m_tid(d_mtid));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
    endtask

    initial begin
        int a_cnt [4];
        int b_cnt [4];
        int d_in  [4];
        int d_out [4];
        int beats, cyc, last_cyc, c_cnt, accepted, buffered, total;
        logic [3:0]  acc4;
        logic [4:0]  acc5;
        logic        bad, xfer, prev_stall;
        logic [15:0] prev_data, exp_data;
        logic [1:0]  prev_tid, exp_tid;

        n_checks = 0;
        n_errors = 0;
        aresetn  = 1'b1;
        a_tdata = '0; a_valid = '0; a_sel = '0; a_mready = 1'b1;
        b_tdata = '0; b_valid = '0; b_sel = '0; b_mready = 1'b1;
        c_tdata = '0; c_valid = '0; c_sel = 3'd2; c_mready = 1'b1;
        d_tdata = '0; d_valid = '0; d_sel = '0; d_mready = 1'b1;

        // ---------------- A: reset state, RR BURST=1 ----------------
        for (int i = 0; i < 4; i++) begin
            a_cnt[i] = 0;
            a_tdata[i*16 +: 16] = 16'(32'h1000 + i);
        end
        a_valid = 4'hF;
        #2;
        aresetn = 1'b0;
        #1;
        chk("rst_mvalid", {63'd0, a_mvalid}, 64'd0);
        chk("rst_mdata",  {48'd0, a_mdata},  64'd0);
        chk("rst_mtid",   {62'd0, a_mtid},   64'd0);
        chk("rst_sready", {60'd0, a_sready}, 64'd0);
        do_reset();
        beats = 0; cyc = 0; last_cyc = 0;
        while (beats < 8 && cyc < 100) begin
            @(negedge aclk);
            if (a_mvalid) begin
                chk("A_tid",  {62'd0, a_mtid},  64'(beats % 4));
                chk("A_data", {48'd0, a_mdata}, 64'(32'h1000 + (beats % 4) + 16 * (beats / 4)));
                if (beats > 0) chk("A_gap", 64'(cyc - last_cyc), 64'd2);
                last_cyc = cyc;
                beats++;
            end
            acc4 = a_valid & a_sready;
            @(posedge aclk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (acc4[i]) begin
                    a_cnt[i]++;
                    a_tdata[i*16 +: 16] = 16'(32'h1000 + i + 16 * a_cnt[i]);
                end
            end
            cyc++;
        end
        chk("A_beats", 64'(beats), 64'd8);
        a_valid = '0;

        // ---------------- B: RR BURST=3, channels 1 and 3 ----------------
        for (int i = 0; i < 4; i++) begin
            b_cnt[i] = 0;
            b_tdata[i*16 +: 16] = 16'(32'h2000 + 256 * i);
        end
        b_valid = 4'b1010;
        do_reset();
        beats = 0; cyc = 0; bad = 1'b0;
        while (beats < 12 && cyc < 200) begin
            @(negedge aclk);
            if ((b_sready & 4'b0101) != 4'b0000) bad = 1'b1;
            if (b_mvalid) begin
                exp_tid = (((beats / 3) % 2) == 0) ? 2'd1 : 2'd3;
                chk("B_tid",  {62'd0, b_mtid},  {62'd0, exp_tid});
                chk("B_data", {48'd0, b_mdata},
                    64'(32'h2000 + 256 * exp_tid + (beats / 6) * 3 + (beats % 3)));
                beats++;
            end
            acc4 = b_valid & b_sready;
            @(posedge aclk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (acc4[i]) begin
                    b_cnt[i]++;
                    b_tdata[i*16 +: 16] = 16'(32'h2000 + 256 * i + b_cnt[i]);
                end
            end
            cyc++;
        end
        chk("B_beats", 64'(beats), 64'd12);
        chk("B_idle_ready", {63'd0, bad}, 64'd0);
        b_valid = '0;

        // ---------------- C: external select, sel=2 then sel=5 ----------------
        c_cnt = 0;
        c_tdata[32 +: 16] = 16'h3000;
        c_valid = 5'b00100;
        c_sel = 3'd2;
        do_reset();
        beats = 0; bad = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge aclk);
            if (k == 0) chk("C_ready_grant", {59'd0, c_sready}, 64'h4);
            if (k >= 2 && c_sready != 5'b00000) bad = 1'b1;
            if (c_mvalid) begin
                chk("C_tid",  {61'd0, c_mtid},  64'd2);
                chk("C_data", {48'd0, c_mdata}, 64'(32'h3000 + beats));
                beats++;
            end
            acc5 = c_valid & c_sready;
            @(posedge aclk);
            #1;
            c_sel = 3'd5;
            if (acc5[2]) begin
                c_cnt++;
                c_tdata[32 +: 16] = 16'(32'h3000 + c_cnt);
            end
        end
        chk("C_beats", 64'(beats), 64'd2);
        chk("C_sel_oob_ready", {63'd0, bad}, 64'd0);
        c_valid = '0;

        // ---------------- D: random backpressure, BURST=4 ----------------
        for (int i = 0; i < 4; i++) begin
            d_in[i]  = 0;
            d_out[i] = 0;
            d_tdata[i*16 +: 16] = 16'(i << 12);
        end
        d_valid = 4'hF;
        d_mready = 1'b0;
        do_reset();
        buffered = 0; total = 0; cyc = 0; prev_stall = 1'b0;
        prev_data = '0; prev_tid = '0;
        while (total < 800 && cyc < 20000) begin
            @(negedge aclk);
            xfer = d_mvalid && d_mready;
            if (prev_stall) begin
                chk("D_stall_valid", {63'd0, d_mvalid}, 64'd1);
                chk("D_stall_data",  {48'd0, d_mdata},  {48'd0, prev_data});
                chk("D_stall_tid",   {62'd0, d_mtid},   {62'd0, prev_tid});
            end
            chk("D_mvalid_occ", {63'd0, d_mvalid}, {63'd0, (buffered != 0)});
            if (buffered == 2) chk("D_ready_full", {60'd0, d_sready}, 64'd0);
            if (xfer) begin
                exp_data = 16'((int'(d_mtid) << 12) | d_out[d_mtid]);
                chk("D_data", {48'd0, d_mdata}, {48'd0, exp_data});
                d_out[d_mtid]++;
                total++;
            end
            prev_stall = d_mvalid && !d_mready;
            prev_data  = d_mdata;
            prev_tid   = d_mtid;
            acc4 = d_valid & d_sready;
            buffered = buffered + $countones(acc4) - (xfer ? 1 : 0);
            @(posedge aclk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (acc4[i]) begin
                    d_in[i]++;
                    if (d_in[i] == 200) d_valid[i] = 1'b0;
                    else d_tdata[i*16 +: 16] = 16'((i << 12) | d_in[i]);
                end
            end
            d_mready = 1'($urandom_range(1, 0));
            cyc++;
        end
        chk("D_total", 64'(total), 64'd800);
        for (int i = 0; i < 4; i++) chk("D_per_chan", 64'(d_out[i]), 64'd200);

        // ---------------- E: reset mid-burst with 2 beats buffered ----------------
        for (int i = 0; i < 4; i++) d_tdata[i*16 +: 16] = 16'(32'h5000 + i);
        d_valid = 4'hF;
        d_mready = 1'b0;
        do_reset();
        accepted = 0; cyc = 0;
        while (cyc < 20) begin
            @(negedge aclk);
            if (accepted == 2 && d_sready == 4'b0000) break;
            accepted = accepted + $countones(d_valid & d_sready);
            @(posedge aclk);
            #1;
            cyc++;
        end
        chk("E_buffered", 64'(accepted), 64'd2);
        chk("E_pre_mvalid", {63'd0, d_mvalid}, 64'd1);
        aresetn = 1'b0;
        #1;
        chk("E_rst_mvalid", {63'd0, d_mvalid}, 64'd0);
        chk("E_rst_sready", {60'd0, d_sready}, 64'd0);
        chk("E_rst_mdata",  {48'd0, d_mdata},  64'd0);
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        aresetn  = 1'b1;
        d_mready = 1'b1;
        beats = 0; cyc = 0;
        while (beats < 5 && cyc < 50) begin
            @(negedge aclk);
            if (d_mvalid) begin
                chk("E_restart_tid", {62'd0, d_mtid}, (beats < 4) ? 64'd0 : 64'd1);
                beats++;
            end
            @(posedge aclk);
            #1;
            cyc++;
        end
        chk("E_restart_beats", 64'(beats), 64'd5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
